// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, NOP encoding and fetch FSM states.
package cpu_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [3:0]  OP_HLT    = 4'hF;
    localparam int unsigned SKID_W    = 32;

    typedef enum logic [1:0] {
        RUN,
        DROP,
        HALT
    } fetch_state_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:12] == OP_HLT;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry {instr, PC_inc} holding register that catches a fetch completing under stall.
module fetch_skid
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              unload,
    input  logic              clear,
    input  logic [SKID_W-1:0] din,
    output logic [SKID_W-1:0] dout,
    output logic              full
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_slice.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, output register and skid for ID stalls.
module if_slice
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] PC_inc,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        halted
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  drop_addr;
    logic [15:0]  instr_q;
    logic [15:0]  pcinc_q;
    logic         valid;
    logic         halted_q;

    logic         skid_full;
    logic [15:0]  skid_instr;
    logic [15:0]  skid_pcinc;
    logic [15:0]  pc_plus1;
    logic         accept;
    logic         skid_load;
    logic         skid_unload;

    always_comb begin
        pc_plus1    = pc + 16'd1;
        imem_req    = !rst && ((state == RUN && !skid_full) || state == DROP);
        imem_addr   = (state == DROP) ? drop_addr : pc;
        accept      = imem_req && imem_ack && (state == RUN) && !redirect;
        skid_load   = accept && stall && valid;
        skid_unload = !redirect && !stall && skid_full;
    end

    fetch_skid u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (redirect),
        .din    ({imem_rdata, pc_plus1}),
        .dout   ({skid_instr, skid_pcinc}),
        .full   (skid_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pcinc_q   <= '0;
            valid     <= 1'b0;
            halted_q  <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            valid    <= 1'b0;
            halted_q <= 1'b0;
            // An unanswered read must still be drained at its original address
            if (imem_req && !imem_ack) begin
                state     <= DROP;
                drop_addr <= imem_addr;
            end else begin
                state <= RUN;
            end
        end else begin
            if (accept) begin
                pc <= pc_plus1;
                if (is_halt(imem_rdata)) begin
                    state    <= HALT;
                    halted_q <= 1'b1;
                end
            end
            if (state == DROP && imem_ack) begin
                state <= RUN;
            end
            if (!stall) begin
                if (skid_full) begin
                    instr_q <= skid_instr;
                    pcinc_q <= skid_pcinc;
                    valid   <= 1'b1;
                end else if (accept) begin
                    instr_q <= imem_rdata;
                    pcinc_q <= pc_plus1;
                    valid   <= 1'b1;
                end else begin
                    valid <= 1'b0;
                end
            end else if (!valid && accept) begin
                instr_q <= imem_rdata;
                pcinc_q <= pc_plus1;
                valid   <= 1'b1;
            end
        end
    end

    always_comb begin
        instr       = valid ? instr_q : NOP_INSTR;
        PC_inc      = pcinc_q;
        instr_valid = valid;
        halted      = halted_q;
    end

endmodule

// File: tb/tb_if_slice.sv
// Directed bench for if_slice against a variable-latency instruction memory model.
module tb_if_slice;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] PC_inc;
    logic [15:0] instr;
    logic        instr_valid;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;

    // Memory model: mem[a] = 16'h1000 + a, optional halt word at 16'h0007
    int unsigned lat = 1;
    int unsigned cnt = 0;
    logic        halt_en = 1'b0;

    always #5 clk = ~clk;

    assign imem_ack   = imem_req && (cnt == lat - 1);
    assign imem_rdata = (halt_en && imem_addr == 16'h0007) ? 16'hF000 : 16'h1000 + imem_addr;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) cnt <= cnt + 1;
        else                       cnt <= 0;
    end

    if_slice #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PC_inc      (PC_inc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] ins, input logic [15:0] pci,
                           input logic vld);
        chk({tag, ".instr"}, {16'h0, instr}, {16'h0, ins});
        chk({tag, ".pcinc"}, {16'h0, PC_inc}, {16'h0, pci});
        chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, vld});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [15:0] addr);
        chk({tag, ".req"}, {31'h0, imem_req}, {31'h0, req});
        if (req) chk({tag, ".addr"}, {16'h0, imem_addr}, {16'h0, addr});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        tick(); tick();
        // reset state
        chk("rst.req", {31'h0, imem_req}, 32'h0);
        chk("rst.addr", {16'h0, imem_addr}, 32'h0);
        chk_out("rst", 16'h0000, 16'h0000, 1'b0);
        chk("rst.halted", {31'h0, halted}, 32'h0);
        rst = 1'b0;
        #1;
        chk_req("first", 1'b1, 16'h0000);

        // 1-cycle memory streams back to back
        tick(); chk_out("s0", 16'h1000, 16'h0001, 1'b1);
        tick(); chk_out("s1", 16'h1001, 16'h0002, 1'b1);
        tick(); chk_out("s2", 16'h1002, 16'h0003, 1'b1);

        // 3-cycle latency: one instruction every 3 cycles
        lat = 3;
        chk_req("l3a", 1'b1, 16'h0003);
        tick(); chk_out("l3b", 16'h0000, 16'h0003, 1'b0); chk_req("l3b", 1'b1, 16'h0003);
        tick(); chk_out("l3c", 16'h0000, 16'h0003, 1'b0); chk_req("l3c", 1'b1, 16'h0003);
        tick(); chk_out("l3d", 16'h1003, 16'h0004, 1'b1); chk_req("l3d", 1'b1, 16'h0004);
        tick(); chk_out("l3e", 16'h0000, 16'h0004, 1'b0); chk_req("l3e", 1'b1, 16'h0004);
        tick(); chk_req("l3f", 1'b1, 16'h0004);
        tick(); chk_out("l3g", 16'h1004, 16'h0005, 1'b1);

        // stall for 4 cycles: skid takes 16'h1006, requests stop
        lat = 1;
        tick(); chk_out("st0", 16'h1005, 16'h0006, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); chk_out("sthold", 16'h1005, 16'h0006, 1'b1); chk_req("sthold", 1'b0, 16'h0000);
        end
        stall = 1'b0;
        tick(); chk_out("rel0", 16'h1006, 16'h0007, 1'b1); chk_req("rel0", 1'b1, 16'h0007);
        tick(); chk_out("rel1", 16'h1007, 16'h0008, 1'b1);

        // redirect with same-cycle ack discards, then redirect while read pending -> DROP
        redirect = 1'b1; redirect_pc = 16'h0005;
        tick(); redirect = 1'b0; lat = 3;
        chk_out("rd0", 16'h0000, 16'h0008, 1'b0); chk_req("rd0", 1'b1, 16'h0005);
        tick();
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick(); redirect = 1'b0;
        chk_req("drop", 1'b1, 16'h0005); chk_out("drop", 16'h0000, 16'h0008, 1'b0);
        tick(); chk_req("dr0", 1'b1, 16'h0040); chk_out("dr0", 16'h0000, 16'h0008, 1'b0);
        tick(); chk_out("dr1", 16'h0000, 16'h0008, 1'b0);
        tick(); chk_out("dr2", 16'h0000, 16'h0008, 1'b0);
        tick(); chk_out("dr3", 16'h1040, 16'h0041, 1'b1);

        // halt word at 16'h0007
        lat = 1; halt_en = 1'b1;
        redirect = 1'b1; redirect_pc = 16'h0007;
        tick(); redirect = 1'b0;
        chk_req("h0", 1'b1, 16'h0007); chk("h0.halted", {31'h0, halted}, 32'h0);
        tick(); chk_out("h1", 16'hF000, 16'h0008, 1'b1);
        chk("h1.halted", {31'h0, halted}, 32'h1); chk_req("h1", 1'b0, 16'h0000);
        tick(); chk_out("h2", 16'h0000, 16'h0008, 1'b0);
        chk("h2.halted", {31'h0, halted}, 32'h1); chk_req("h2", 1'b0, 16'h0000);
        tick(); chk_req("h3", 1'b0, 16'h0000);
        redirect = 1'b1; redirect_pc = 16'h0020;
        tick(); redirect = 1'b0;
        chk("h4.halted", {31'h0, halted}, 32'h0); chk_req("h4", 1'b1, 16'h0020);
        tick(); chk_out("h5", 16'h1020, 16'h0021, 1'b1);

        // PC wrap at 16'hFFFF
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick(); redirect = 1'b0;
        chk_req("w0", 1'b1, 16'hFFFF);
        tick(); chk_out("w1", 16'h0FFF, 16'h0000, 1'b1); chk_req("w1", 1'b1, 16'h0000);
        tick(); chk_out("w2", 16'h1000, 16'h0001, 1'b1);

        // reset during a pending request
        lat = 3;
        tick(); chk_req("rp0", 1'b1, 16'h0001);
        rst = 1'b1;
        tick();
        chk_req("rp1", 1'b0, 16'h0000);
        chk("rp1.addr", {16'h0, imem_addr}, 32'h0);
        chk_out("rp1", 16'h0000, 16'h0000, 1'b0);
        chk("rp1.halted", {31'h0, halted}, 32'h0);
        rst = 1'b0;
        #1;
        chk_req("rp2", 1'b1, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/if_slice.md
# if_slice

Instruction-fetch stage of the 5-stage pipeline, directly upstream of ID. Owns the PC and issues word reads to a variable-latency instruction memory over a req/ack handshake. Presents one instruction plus its incremented PC per cycle to ID, holds it under `stall`, and squashes on `redirect` from branch, call or return resolution. A 1-entry skid buffer absorbs a fetch that completes while ID is stalled. Stops fetching after a halt opcode.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded by reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  hazard hold from ID; output registers and PC hold.
- `redirect`  in  1  control-flow change; squash and refetch.
- `redirect_pc`  in  16  target PC, valid while `redirect`=1.
- `imem_req`  out  1  read request.
- `imem_addr`  out  16  word address; stable while `imem_req`=1 until ack.
- `imem_ack`  in  1  read data valid this cycle; sampled only when `imem_req`=1.
- `imem_rdata`  in  16  instruction word.
- `PC_inc`  out  16  fetched PC + 1, feeds ID `PC_inc_in`.
- `instr`  out  16  fetched instruction, feeds ID `instr_in`; NOP (16'h0000) when invalid.
- `instr_valid`  out  1  `instr`/`PC_inc` hold a real fetch.
- `halted`  out  1  halt opcode delivered; fetch stopped.

## Operation
- State: `pc` (16b), output register {`instr_q`, `pcinc_q`, `valid`}, skid register {`skid_instr`, `skid_pcinc`, `skid_valid`}, FSM `{RUN, DROP, HALT}`.
- Priority each cycle: `rst` > `redirect` > ack/stall handling.
- RUN:
  - `imem_req`=1 when `skid_valid`=0.
  - `imem_addr`=`pc`.
  - On ack: `pc`<=`pc`+1, wrapping 16'hFFFF to 16'h0000. Data with `PC_inc`=`pc`+1 goes to the output register if `stall`=0 (or the output is invalid), else to the skid.
- Stall:
  - Output register holds.
  - When `stall` falls: the skid moves to the output next cycle, and a new ack in that cycle goes to the skid.
- Halt opcode:
  - An accepted word with `imem_rdata[15:12]`=4'hF moves the FSM to HALT. It is still delivered once.
  - In HALT: no requests. After the halt word leaves the output, `instr`=NOP and `valid`=0.
  - `halted`=1 from the cycle after the halt word is accepted.
- `redirect`:
  - `pc`<=`redirect_pc`; `valid` and `skid_valid` are cleared.
  - If a request is outstanding with no ack this cycle: go to DROP.
  - Otherwise go to RUN, including a redirect with a same-cycle ack (that data is discarded) and a redirect from HALT (the speculative halt is cancelled; `halted` returns to 0).
- DROP:
  - Keep `imem_req`=1 with the old `imem_addr` until ack, then discard the data.
  - Next cycle: RUN, requesting `pc`.
  - A redirect in DROP updates `pc` only and stays in DROP.
- Output mux: `instr`=`valid` ? `instr_q` : 16'h0000; `PC_inc`=`pcinc_q`.

## Timing
- Reset values:
  - `pc`=`RESET_PC`; FSM=RUN.
  - `imem_req`=0 in the reset cycle; first request in the first cycle after `rst` deasserts.
  - `imem_addr`=`RESET_PC`, `instr`=16'h0000, `PC_inc`=16'h0000, `instr_valid`=0, `halted`=0.
- Latency: ack in cycle t puts the instruction on `instr` in cycle t+1, which ID captures at the end of t+1.
- With a 1-cycle-ack memory and no stall: one instruction per cycle, back-to-back.
- `redirect` in cycle t: `instr`=NOP in t+1. Request to `redirect_pc` in t+1, or in the cycle after the drop ack when in DROP.
- `rst` mid-transaction: abandons any outstanding request with no drop. `imem_req` drops at the next edge; the memory must tolerate an abandoned request.
- Skid full and stall held: `imem_req`=0 and no instruction is lost.

## Structure
- Shared package `cpu_pkg`: `NOP_INSTR`=16'h0000, `OP_HLT`=4'hF, enum `fetch_state_t {RUN, DROP, HALT}`. Opcode constants live here for reuse by ID control.
- Sub-module `fetch_skid`: 1-entry 32-bit {instr, PC_inc} holding register with load/unload/clear and `full`.
- Top `if_slice` holds the PC, FSM, output register and request logic. Target size: 150-250 lines.

## Test plan
- Reset, memory acks every cycle with `mem[a]`=16'h1000+a → `instr` sequence 16'h1000, 16'h1001, 16'h1002 with `PC_inc` 1, 2, 3; first `imem_req` the cycle after `rst` falls.
- 3-cycle ack latency → one instruction every 3 cycles; `imem_addr` stable while `imem_req`=1; NOP/`instr_valid`=0 between deliveries.
- `stall` held 4 cycles, 1-cycle memory → output holds; the skid takes exactly one word; `imem_req`=0 afterward; on release the words are delivered in order with none lost or duplicated.
- `redirect`=1, `redirect_pc`=16'h0040 while a 3-cycle read of 16'h0005 is pending → DROP; late data discarded; next request `imem_addr`=16'h0040; `instr` NOP until 16'h0040's word arrives.
- Memory returns 16'hF000 at 16'h0007 → delivered once with `PC_inc`=16'h0008; `halted`=1; `imem_req` stays 0; then a redirect to 16'h0020 → `halted`=0 and fetch resumes at 16'h0020.
- Edge cases: PC 16'hFFFF wraps to `PC_inc`=16'h0000 and next fetch 16'h0000; assert `rst` during a pending request → all outputs return to reset values next cycle.
